// File: rtl/cdb_writeback.sv
// Common Data Bus writeback: per-source hold registers, one-grant-per-cycle arbiter,
// register status (Qi) table and register file write port. CDB_ROUND_ROBIN_EN selects rotating priority.
module cdb_writeback #(
  parameter int DATA_W = 16,
  parameter int TAG_W  = 3
) (
  input  logic              clock,
  input  logic              resetN,
  input  logic              issueValid,
  input  logic [2:0]        issueDest,
  input  logic [TAG_W-1:0]  issueTag,
  input  logic              addValid,
  output logic              addReady,
  input  logic [TAG_W-1:0]  addTag,
  input  logic [DATA_W-1:0] addResult,
  input  logic              mulValid,
  output logic              mulReady,
  input  logic [TAG_W-1:0]  mulTag,
  input  logic [DATA_W-1:0] mulResult,
  input  logic              ldValid,
  output logic              ldReady,
  input  logic [TAG_W-1:0]  ldTag,
  input  logic [DATA_W-1:0] ldResult,
  output logic              cdbValid,
  output logic [TAG_W-1:0]  cdbTag,
  output logic [DATA_W-1:0] cdbData,
  output logic [DATA_W-1:0] dataIn,
  output logic [2:0]        dataAddress,
  output logic              writeEnable,
  output logic [6:0]        regBusy
);

  localparam int NSRC = 3;

  // Handshake: a source result transfers on the rising edge where valid & ready are both high;
  // the source must hold valid and payload stable until then. Ready is high when the
  // hold register is empty or is being granted onto the CDB in the same cycle.
  logic [NSRC-1:0]              src_valid;
  logic [NSRC-1:0][TAG_W-1:0]   src_tag;
  logic [NSRC-1:0][DATA_W-1:0]  src_data;
  logic [NSRC-1:0]              ready;
  logic [NSRC-1:0]              hold_valid;
  logic [NSRC-1:0][TAG_W-1:0]   hold_tag;
  logic [NSRC-1:0][DATA_W-1:0]  hold_data;
  logic [NSRC-1:0]              grant;
  logic [1:0]                   grant_idx;
  logic                         any_grant;
  logic [TAG_W-1:0]             sel_tag;
  logic [DATA_W-1:0]            sel_data;
  logic [7:1][TAG_W-1:0]        qi;
  logic [7:1][TAG_W-1:0]        qi_next;
  logic [6:0]                   busy_next;
  logic                         match_found;
  logic [2:0]                   match_idx;

  assign src_valid = {ldValid, mulValid, addValid};
  assign src_tag   = {ldTag, mulTag, addTag};
  assign src_data  = {ldResult, mulResult, addResult};

  assign ready    = {NSRC{resetN}} & (~hold_valid | grant);
  assign addReady = ready[0];
  assign mulReady = ready[1];
  assign ldReady  = ready[2];

`ifdef CDB_ROUND_ROBIN_EN
  logic [1:0] rr_ptr;
  logic [1:0] rr_ptr_next;
  logic [1:0] cand;

  function automatic logic [1:0] rr_wrap(input logic [1:0] a, input logic [1:0] b);
    logic [2:0] sum;
    sum = {1'b0, a} + {1'b0, b};
    return (sum >= 3'd3) ? 2'(sum - 3'd3) : sum[1:0];
  endfunction

  // Search starts at the pointer; after a grant the pointer moves just past the winner.
  always_comb begin
    grant       = '0;
    grant_idx   = '0;
    rr_ptr_next = rr_ptr;
    cand        = '0;
    for (int off = 0; off < NSRC; off++) begin
      cand = rr_wrap(rr_ptr, 2'(off));
      if (grant == '0 && hold_valid[cand]) begin
        grant[cand] = 1'b1;
        grant_idx   = cand;
        rr_ptr_next = rr_wrap(cand, 2'd1);
      end
    end
  end

  always_ff @(posedge clock or negedge resetN) begin
    if (!resetN) rr_ptr <= '0;
    else         rr_ptr <= rr_ptr_next;
  end
`else
  always_comb begin
    grant     = '0;
    grant_idx = '0;
    if (hold_valid[2]) begin
      grant[2]  = 1'b1;
      grant_idx = 2'd2;
    end else if (hold_valid[1]) begin
      grant[1]  = 1'b1;
      grant_idx = 2'd1;
    end else if (hold_valid[0]) begin
      grant[0]  = 1'b1;
      grant_idx = 2'd0;
    end
  end
`endif

  assign any_grant = |grant;
  assign sel_tag   = hold_tag[grant_idx];
  assign sel_data  = hold_data[grant_idx];

  // Match against pre-edge Qi; an issue to the same register overrides the clear.
  always_comb begin
    match_found = 1'b0;
    match_idx   = '0;
    for (int k = 1; k <= 7; k++) begin
      if (!match_found && any_grant && qi[k] == sel_tag) begin
        match_found = 1'b1;
        match_idx   = 3'(k);
      end
    end
    qi_next = qi;
    if (match_found) qi_next[match_idx] = '0;
    if (issueValid && issueDest != 3'd0) qi_next[issueDest] = issueTag;
    busy_next = '0;
    for (int k = 1; k <= 7; k++) busy_next[k-1] = |qi_next[k];
  end

  // Tag-0 results complete the handshake but never occupy the hold register.
  always_ff @(posedge clock or negedge resetN) begin
    if (!resetN) begin
      hold_valid <= '0;
      hold_tag   <= '0;
      hold_data  <= '0;
    end else begin
      for (int s = 0; s < NSRC; s++) begin
        if (src_valid[s] && ready[s]) begin
          hold_valid[s] <= |src_tag[s];
          hold_tag[s]   <= src_tag[s];
          hold_data[s]  <= src_data[s];
        end else if (grant[s]) begin
          hold_valid[s] <= 1'b0;
        end
      end
    end
  end

  always_ff @(posedge clock or negedge resetN) begin
    if (!resetN) begin
      qi          <= '0;
      regBusy     <= '0;
      cdbValid    <= 1'b0;
      cdbTag      <= '0;
      cdbData     <= '0;
      writeEnable <= 1'b0;
      dataAddress <= '0;
      dataIn      <= '0;
    end else begin
      qi      <= qi_next;
      regBusy <= busy_next;
      if (any_grant) begin
        cdbValid    <= 1'b1;
        cdbTag      <= sel_tag;
        cdbData     <= sel_data;
        writeEnable <= match_found;
        dataAddress <= match_found ? match_idx : 3'd0;
        if (match_found) dataIn <= sel_data;
      end else begin
        cdbValid    <= 1'b0;
        writeEnable <= 1'b0;
        dataAddress <= '0;
      end
    end
  end

endmodule

// File: tb/tb_cdb_writeback.sv
// Self-checking bench for cdb_writeback: directed scenarios plus random traffic,
// each edge predicted by a behavioural model of holds, arbitration and register status.
module tb_cdb_writeback;

  localparam int DATA_W = 16;
  localparam int TAG_W  = 3;

  logic              clock;
  logic              resetN;
  logic              issueValid;
  logic [2:0]        issueDest;
  logic [TAG_W-1:0]  issueTag;
  logic [2:0]        src_v;
  logic [TAG_W-1:0]  src_t [3];
  logic [DATA_W-1:0] src_d [3];
  logic              addReady, mulReady, ldReady;
  logic              cdbValid;
  logic [TAG_W-1:0]  cdbTag;
  logic [DATA_W-1:0] cdbData;
  logic [DATA_W-1:0] dataIn;
  logic [2:0]        dataAddress;
  logic              writeEnable;
  logic [6:0]        regBusy;

  cdb_writeback #(.DATA_W(DATA_W), .TAG_W(TAG_W)) dut (
    .clock(clock), .resetN(resetN),
    .issueValid(issueValid), .issueDest(issueDest), .issueTag(issueTag),
    .addValid(src_v[0]), .addReady(addReady), .addTag(src_t[0]), .addResult(src_d[0]),
    .mulValid(src_v[1]), .mulReady(mulReady), .mulTag(src_t[1]), .mulResult(src_d[1]),
    .ldValid(src_v[2]), .ldReady(ldReady), .ldTag(src_t[2]), .ldResult(src_d[2]),
    .cdbValid(cdbValid), .cdbTag(cdbTag), .cdbData(cdbData),
    .dataIn(dataIn), .dataAddress(dataAddress), .writeEnable(writeEnable),
    .regBusy(regBusy)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  int compared;
  int mismatched;

  // Reference model state: one pending result per source, arbiter pointer, Qi table.
  bit                m_hv [3];
  int                m_ht [3];
  int                m_hd [3];
  int                m_ptr;
  int                m_qi [8];
  bit   [2:0]        last_acc;
  logic [TAG_W+DATA_W-1:0] exp_q [$];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int s = 0; s < 3; s++) begin
      m_hv[s] = 0; m_ht[s] = 0; m_hd[s] = 0;
    end
    m_ptr = 0;
    for (int k = 0; k < 8; k++) m_qi[k] = 0;
    exp_q.delete();
    last_acc = '0;
  endtask

  task automatic idle_inputs();
    src_v = '0;
    issueValid = 1'b0; issueDest = '0; issueTag = '0;
    for (int s = 0; s < 3; s++) begin
      src_t[s] = '0; src_d[s] = '0;
    end
  endtask

  task automatic set_src(input int s, input int tag, input int data);
    src_v[s] = 1'b1;
    src_t[s] = TAG_W'(tag);
    src_d[s] = DATA_W'(data);
  endtask

  task automatic set_issue(input int dest, input int tag);
    issueValid = 1'b1;
    issueDest  = 3'(dest);
    issueTag   = TAG_W'(tag);
  endtask

  // Predicts one clock edge from the current inputs, then checks the DUT after it.
  task automatic step();
    int gi, fk, gdata;
    logic [2:0] exp_rdy;
    logic [6:0] eb;
    logic [TAG_W+DATA_W-1:0] e;
    gi = -1;
`ifdef CDB_ROUND_ROBIN_EN
    for (int off = 0; off < 3; off++) begin
      int s;
      s = (m_ptr + off) % 3;
      if (gi < 0 && m_hv[s]) gi = s;
    end
`else
    for (int s = 2; s >= 0; s--) if (gi < 0 && m_hv[s]) gi = s;
`endif
    for (int s = 0; s < 3; s++) exp_rdy[s] = !m_hv[s] || gi == s;
    check("ready", {29'd0, ldReady, mulReady, addReady}, {29'd0, exp_rdy});
    fk = 0;
    gdata = 0;
    if (gi >= 0) begin
      gdata = m_hd[gi];
      for (int k = 1; k <= 7; k++) if (m_qi[k] == m_ht[gi]) fk = k;
      exp_q.push_back({TAG_W'(m_ht[gi]), DATA_W'(m_hd[gi])});
      m_ptr = (gi + 1) % 3;
    end
    for (int s = 0; s < 3; s++) begin
      last_acc[s] = src_v[s] && exp_rdy[s];
      if (last_acc[s]) begin
        m_hv[s] = (src_t[s] != 0);
        m_ht[s] = int'(src_t[s]);
        m_hd[s] = int'(src_d[s]);
      end else if (gi == s) begin
        m_hv[s] = 0;
      end
    end
    if (fk != 0) m_qi[fk] = 0;
    if (issueValid && issueDest != 0) m_qi[issueDest] = int'(issueTag);
    for (int k = 1; k <= 7; k++) eb[k-1] = (m_qi[k] != 0);
    @(posedge clock);
    #1;
    check("cdb_valid", {31'd0, cdbValid}, {31'd0, gi >= 0});
    if (cdbValid) begin
      if (exp_q.size() == 0) check("sb_unexpected", 32'd1, 32'd0);
      else begin
        e = exp_q.pop_front();
        check("sb_tag_data", {13'd0, cdbTag, cdbData}, {13'd0, e});
      end
    end
    check("write_enable", {31'd0, writeEnable}, {31'd0, fk != 0});
    check("data_address", {29'd0, dataAddress}, 32'(fk));
    if (fk != 0) check("data_in", {16'd0, dataIn}, 32'(gdata) & 32'hFFFF);
    check("reg_busy", {25'd0, regBusy}, {25'd0, eb});
  endtask

  task automatic drop_accepted();
    for (int s = 0; s < 3; s++) if (last_acc[s]) src_v[s] = 1'b0;
  endtask

  task automatic drain(input int n);
    idle_inputs();
    repeat (n) step();
  endtask

  task automatic check_outputs_zero(input string pfx);
    check({pfx, "_cdb_valid"}, {31'd0, cdbValid}, 32'd0);
    check({pfx, "_cdb_tag"}, {29'd0, cdbTag}, 32'd0);
    check({pfx, "_cdb_data"}, {16'd0, cdbData}, 32'd0);
    check({pfx, "_write_enable"}, {31'd0, writeEnable}, 32'd0);
    check({pfx, "_data_address"}, {29'd0, dataAddress}, 32'd0);
    check({pfx, "_data_in"}, {16'd0, dataIn}, 32'd0);
    check({pfx, "_reg_busy"}, {25'd0, regBusy}, 32'd0);
  endtask

  initial begin
    int tg, dst, seq;
    compared = 0;
    mismatched = 0;
    resetN = 1'b0;
    idle_inputs();
    model_reset();

    // Reset state
    repeat (2) @(negedge clock);
    check_outputs_zero("rst");
    resetN = 1'b1;
    #1;
    check("rst_ready", {29'd0, ldReady, mulReady, addReady}, 32'd7);

    // Issue R3 tag 2, add returns tag 2 value 4A00
    set_issue(3, 2);
    step();
    check("t2_busy_set", {31'd0, regBusy[2]}, 32'd1);
    idle_inputs();
    set_src(0, 2, 16'h4A00);
    step();
    idle_inputs();
    step();
    check("t2_cdb_tag", {29'd0, cdbTag}, 32'd2);
    check("t2_we", {31'd0, writeEnable}, 32'd1);
    check("t2_addr", {29'd0, dataAddress}, 32'd3);
    check("t2_din", {16'd0, dataIn}, 32'h4A00);
    check("t2_busy_clr", {31'd0, regBusy[2]}, 32'd0);
    step();
    check("t2_pulse", {31'd0, cdbValid}, 32'd0);

    // WAW on R5
    set_issue(5, 1);
    step();
    set_issue(5, 4);
    step();
    idle_inputs();
    set_src(1, 1, 16'hBEEF);
    step();
    idle_inputs();
    step();
    check("waw_tag", {29'd0, cdbTag}, 32'd1);
    check("waw_we", {31'd0, writeEnable}, 32'd0);
    check("waw_busy", {31'd0, regBusy[4]}, 32'd1);
    set_src(2, 4, 16'h1357);
    step();
    idle_inputs();
    step();
    check("waw2_we", {31'd0, writeEnable}, 32'd1);
    check("waw2_addr", {29'd0, dataAddress}, 32'd5);
    check("waw2_busy", {31'd0, regBusy[4]}, 32'd0);

    // All three sources offering every cycle
    seq = 0;
    for (int s = 0; s < 3; s++) begin
      seq++;
      set_src(s, (seq % 7) + 1, 16'h1000 + seq);
    end
    for (int i = 0; i < 12; i++) begin
      step();
      for (int s = 0; s < 3; s++) if (last_acc[s]) begin
        seq++;
        set_src(s, (seq % 7) + 1, 16'h1000 + seq);
      end
    end
    drain(5);

    // Same-cycle issue and matching broadcast on R2
    set_issue(2, 3);
    step();
    idle_inputs();
    set_src(0, 3, 16'h1234);
    step();
    idle_inputs();
    set_issue(2, 6);
    step();
    check("same_we", {31'd0, writeEnable}, 32'd1);
    check("same_addr", {29'd0, dataAddress}, 32'd2);
    check("same_din", {16'd0, dataIn}, 32'h1234);
    check("same_busy", {31'd0, regBusy[1]}, 32'd1);
    drain(2);

    // Tag-0 result from the load buffer
    set_src(2, 0, 16'h5555);
    step();
    check("tag0_acc", {31'd0, last_acc[2]}, 32'd1);
    idle_inputs();
    step();
    check("tag0_nocdb", {31'd0, cdbValid}, 32'd0);

    // Random traffic
    idle_inputs();
    for (int i = 0; i < 400; i++) begin
      for (int s = 0; s < 3; s++) begin
        if (!src_v[s] || last_acc[s]) begin
          src_v[s] = ($urandom_range(0, 3) != 0);
          src_t[s] = TAG_W'($urandom_range(0, 7));
          src_d[s] = DATA_W'($urandom);
        end
      end
      issueValid = 1'b0;
      if ($urandom_range(0, 1) == 1) begin
        dst = $urandom_range(0, 7);
        tg = $urandom_range(0, 7);
        for (int k = 1; k <= 7; k++) if (k != dst && m_qi[k] == tg) tg = 0;
        set_issue(dst, tg);
      end
      step();
    end
    drain(6);
    check("sb_leftover", 32'(exp_q.size()), 32'd0);

    // Reset mid-traffic with all three holds full
    set_issue(1, 5);
    step();
    idle_inputs();
    set_src(0, 1, 16'hA1A1);
    set_src(1, 2, 16'hB2B2);
    set_src(2, 3, 16'hC3C3);
    step();
    idle_inputs();
    #2;
    resetN = 1'b0;
    #1;
    check_outputs_zero("midrst");
    repeat (2) @(negedge clock);
    model_reset();
    resetN = 1'b1;
    #1;
    check("midrst_ready", {29'd0, ldReady, mulReady, addReady}, 32'd7);
    repeat (3) step();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
